// File: rtl/cache_pkg.sv
// cache_pkg: shared types and helpers for the data-cache sequencing controller.
//   state_t       - controller FSM states
//   CACHE_ADDR_W  - default byte address width (DDR2 space)
//   CACHE_DATA_W  - default word width
//   CACHE_CNT_W   - default statistics counter width
//   word_align()  - clears the byte offset of a byte address
package cache_pkg;

  localparam int unsigned CACHE_ADDR_W = 27;
  localparam int unsigned CACHE_DATA_W = 32;
  localparam int unsigned CACHE_CNT_W  = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_RD_REQ,
    S_RD_WAIT,
    S_FILL,
    S_WR_REQ,
    S_DONE
  } state_t;

  // Word-aligned form of a byte address (low two bits forced to zero)
  function automatic logic [CACHE_ADDR_W-1:0] word_align(input logic [CACHE_ADDR_W-1:0] addr);
    return {addr[CACHE_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter that increments on inc and holds at all-ones.
//   clk, rstn - clock, asynchronous active-low reset
//   inc       - increment request
//   count     - current count (registered)
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: sequencing controller for a direct-mapped, word-addressed data
// cache. One load/store at a time; read misses fetch from DDR2 and fill the
// cache; stores are write-through with no write-allocate.
//   core port : req_valid/req_ready/req_write/req_addr/req_wdata,
//               resp_valid/resp_rdata
//   cache port: cache_addr, cache_hit, cache_rdata, cache_fill, cache_wr,
//               cache_wdata
//   DDR2 port : mem_req_valid/mem_req_ready/mem_write/mem_addr/mem_wdata,
//               mem_rvalid/mem_rdata
//   stats     : hit_count, miss_count (saturating)
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = CACHE_ADDR_W,
  parameter int unsigned DATA_W = CACHE_DATA_W,
  parameter int unsigned CNT_W  = CACHE_CNT_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] cache_addr,
  input  logic              cache_hit,
  input  logic [DATA_W-1:0] cache_rdata,
  output logic              cache_fill,
  output logic              cache_wr,
  output logic [DATA_W-1:0] cache_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_hit;

  logic w_idle, w_lookup, w_rd_req, w_fill, w_wr_req, w_done;
  logic w_load_hit;

  // Controller FSM plus request/response latches
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_hit   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_write <= req_write;
            r_wdata <= req_wdata;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_hit <= cache_hit;
          if (r_write)        r_state <= S_WR_REQ;
          else if (cache_hit) r_state <= S_IDLE;
          else                r_state <= S_RD_REQ;
        end
        S_RD_REQ:  if (mem_req_ready) r_state <= S_RD_WAIT;
        S_RD_WAIT: begin
          if (mem_rvalid) begin
            r_rdata <= mem_rdata;
            r_state <= S_FILL;
          end
        end
        S_FILL:    r_state <= S_IDLE;
        S_WR_REQ:  if (mem_req_ready) r_state <= S_DONE;
        S_DONE:    r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign w_idle     = (r_state == S_IDLE);
  assign w_lookup   = (r_state == S_LOOKUP);
  assign w_rd_req   = (r_state == S_RD_REQ);
  assign w_fill     = (r_state == S_FILL);
  assign w_wr_req   = (r_state == S_WR_REQ);
  assign w_done     = (r_state == S_DONE);
  // Load hits answer straight from the array during the lookup cycle
  assign w_load_hit = w_lookup && !r_write && cache_hit;

  assign req_ready     = w_idle;
  assign resp_valid    = w_load_hit || w_fill || w_done;
  assign resp_rdata    = w_load_hit ? cache_rdata : (w_fill ? r_rdata : '0);
  assign cache_addr    = w_idle ? req_addr : r_addr;
  assign cache_fill    = w_fill;
  // Store hits update the array only once DDR2 has taken the write
  assign cache_wr      = w_wr_req && mem_req_ready && r_hit;
  assign cache_wdata   = w_fill ? r_rdata : (w_wr_req ? r_wdata : '0);
  assign mem_req_valid = w_rd_req || w_wr_req;
  assign mem_write     = w_wr_req;
  assign mem_addr      = ADDR_W'(word_align(CACHE_ADDR_W'(r_addr)));
  assign mem_wdata     = w_wr_req ? r_wdata : '0;

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (w_lookup && cache_hit),
    .count (hit_count)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (w_lookup && !cache_hit),
    .count (miss_count)
  );

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Sequencing controller for the direct-mapped, word-addressed data cache. It accepts one load/store at a time from the core, runs the cache lookup, and on a read miss fetches the word from DDR2 and fills the cache. Stores are write-through with no write-allocate. It sits between the core's memory port, the cache array, and the DDR2 memory interface, and keeps saturating hit/miss counters for performance monitoring.

## Interface
- ADDR_W, 27, byte address width (DDR2 space)
- DATA_W, 32, word width
- CNT_W, 32, width of each statistics counter

- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  controller can accept a request
- req_write  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address; bits [1:0] ignored
- req_wdata  in  DATA_W  store data
- resp_valid  out  1  one-cycle pulse: load data valid or store complete
- resp_rdata  out  DATA_W  load data; 0 for stores
- cache_addr  out  ADDR_W  lookup/fill/write address to the cache array
- cache_hit  in  1  combinational hit for cache_addr
- cache_rdata  in  DATA_W  combinational data for cache_addr
- cache_fill  out  1  write cache_wdata and the tag at cache_addr
- cache_wr  out  1  update data on a store hit; tag unchanged
- cache_wdata  out  DATA_W  fill or store data
- mem_req_valid  out  1  DDR2 request valid
- mem_req_ready  in  1  DDR2 accepts request
- mem_write  out  1  DDR2 request is a write
- mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- mem_wdata  out  DATA_W  DDR2 write data
- mem_rvalid  in  1  DDR2 read data valid
- mem_rdata  in  DATA_W  DDR2 read data
- hit_count  out  CNT_W  saturating count of lookup hits
- miss_count  out  CNT_W  saturating count of lookup misses

## Operation
- States: IDLE, LOOKUP, RD_REQ, RD_WAIT, FILL, WR_REQ, DONE.
- IDLE: req_ready=1. On req_valid, latch addr, write, and wdata, then go to LOOKUP. No other state asserts req_ready.
- LOOKUP: cache_addr = latched addr. Sample cache_hit and cache_rdata, and latch the hit flag.
  - Load hit: resp_valid=1 and resp_rdata=cache_rdata this cycle, then IDLE.
  - Load miss: go to RD_REQ.
  - Store (hit or miss): go to WR_REQ.
- RD_REQ: mem_req_valid=1 and mem_write=0, held until mem_req_ready, then RD_WAIT.
- RD_WAIT: wait for mem_rvalid. On mem_rvalid, latch mem_rdata and go to FILL.
- FILL: cache_fill=1, cache_wdata = latched data, resp_valid=1, resp_rdata = latched data, then IDLE.
- WR_REQ: mem_req_valid=1, mem_write=1, mem_wdata = latched wdata, held until mem_req_ready.
  - In the handshake cycle, cache_wr = latched hit flag and cache_wdata = wdata.
  - Then go to DONE.
- DONE: resp_valid=1 and resp_rdata=0, then IDLE.
- Counters:
  - Each LOOKUP cycle increments exactly one of hit_count or miss_count, for loads and stores alike.
  - Each counter saturates at all-ones.
- mem_rvalid outside RD_WAIT is ignored.
- mem_req_ready outside RD_REQ/WR_REQ is ignored.
- cache_addr equals the latched address in every state except IDLE, where it follows req_addr.

## Timing
- Reset values:
  - State = IDLE, so req_ready=1.
  - All other single-bit outputs = 0.
  - resp_rdata, cache_wdata, mem_wdata = 0.
  - Counters = 0.
- Latency, counted from the accept edge to the resp_valid cycle:
  - Load hit: 1 cycle (the LOOKUP cycle).
  - Load miss: 3 + request-wait cycles + read-latency cycles. Minimum 4 with immediate ready and mem_rvalid one cycle after acceptance.
  - Store: 3 + request-wait cycles.
- mem_req_valid and its address, write, and data signals stay stable until the handshake. They deassert in the cycle after the handshake.
- resp_valid is exactly one cycle wide. There is no response backpressure.
- Back-to-back: the next request is accepted in the first IDLE cycle after resp_valid, so a load hit sustains one request per 2 cycles.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values.
  - An in-flight DDR2 read whose mem_rvalid arrives later is dropped.
  - No cache_fill or cache_wr occurs for the aborted request.

## Structure
- cache_pkg holds:
  - typedef enum for the states
  - ADDR_W and DATA_W defaults
  - the function word_align(addr)
- One sub-module: sat_counter (parameter W, inputs inc/clk/rstn, output count), instantiated twice for hit_count and miss_count.
- Everything else lives in cache_ctrl: a single registered FSM plus request latches.

## Test plan
- Reset, then load 0x0000100 with cache_hit=1 and cache_rdata=0xDEADBEEF.
  - resp_valid one cycle after accept with rdata 0xDEADBEEF.
  - hit_count=1, no mem_req_valid.
- Load 0x0000200 with cache_hit=0; DDR2 ready after 2 cycles and mem_rvalid 5 cycles later with 0x12345678.
  - mem_addr=0x0000200 held until ready.
  - cache_fill pulse and resp_rdata 0x12345678 in the same cycle.
  - miss_count=1.
- Store 0x0000303 with data 0xA5A5A5A5 and cache_hit=1.
  - mem_addr=0x0000300, mem_write=1.
  - cache_wr in the handshake cycle.
  - resp_valid the next cycle with rdata 0.
- Store with cache_hit=0.
  - No cache_wr and no cache_fill, DDR2 write issued, miss_count increments.
- Load miss with rstn pulsed low during RD_WAIT, and a late mem_rvalid after release.
  - All outputs return to reset values.
  - The late mem_rvalid causes no fill and no resp_valid.
- Preload hit_count near all-ones (force or small CNT_W=2), then 5 load hits.
  - hit_count stops at 3.
